cmd_fetch: RTL and testbench
============================

// Module: cmd_fetch
// PURPOSE
//  Read-side sequencer for the command memory. Drives the memory address port
//  and absorbs the memory's one-cycle read latency (address registered inside
//  the memory, data combinational from that register). Presents one command
//  per cycle to the processor core over a valid/ready handshake, using a
//  2-entry skid buffer. Supports start, jump (branch redirect) and stop.
// PARAMETERS
//  CMD_WIDTH   128  command word width; matches the memory data width
//  ADDR_WIDTH  8    memory address width; depth = 2**ADDR_WIDTH
// PORTS
//  clk         in   1           clock
//  reset       in   1           asynchronous, active-high reset
//  start       in   1           begin fetching at start_addr; honoured only in IDLE
//  start_addr  in   ADDR_WIDTH  first command address
//  stop        in   1           abandon fetching and return to IDLE
//  jump_en     in   1           redirect fetch to jump_addr; honoured only in RUN
//  jump_addr   in   ADDR_WIDTH  jump target
//  mem_addr    out  ADDR_WIDTH  memory address; equals fetch_ptr (combinational from that register)
//  mem_cmd     in   CMD_WIDTH   memory read data (data for mem_addr sampled at previous edge)
//  cmd_out     out  CMD_WIDTH   command at head of skid buffer
//  cmd_pc      out  ADDR_WIDTH  address cmd_out was fetched from
//  cmd_valid   out  1           cmd_out/cmd_pc valid
//  cmd_ready   in   1           consumer accepts; transfer = cmd_valid & cmd_ready
//  busy        out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, fetch_ptr=0, buffer empty, in-flight flag clear;
//   mem_addr=0, cmd_out=0, cmd_pc=0, cmd_valid=0, busy=0.
//  States: IDLE -> RUN on start. RUN -> IDLE on stop.
//   start while busy is ignored.
//  Read issue: in RUN, a read is issued at an edge when
//   (buffered + in_flight) < 2 after that edge's dequeue.
//   The memory latches mem_addr at that edge. fetch_ptr increments and the
//   in-flight flag is set with the issued address. At the next edge mem_cmd
//   is written into the buffer with that address.
//  Latency: start at edge E -> mem_addr=start_addr after E. cmd_valid is high
//   after E+2 with cmd_out=mem[start_addr] and cmd_pc=start_addr.
//  Throughput: with cmd_ready held high, one command per cycle at sequential
//   addresses. No bubbles after the first.
//  Backpressure: cmd_out/cmd_pc are held stable while cmd_valid & !cmd_ready.
//   No command is dropped or duplicated. The buffer never exceeds 2 entries.
//  Wrap: fetch_ptr increments modulo 2**ADDR_WIDTH (max -> 0); no flag.
//  Jump at edge J (RUN only):
//   - a transfer at J still completes;
//   - buffer and in-flight read are then discarded;
//   - fetch_ptr=jump_addr;
//   - cmd_valid=0 after J. First command mem[jump_addr] is valid after J+2.
//  stop at edge S: buffer and in-flight read are discarded and state=IDLE.
//   After S, cmd_valid=0 and busy=0. fetch_ptr holds, so mem_addr holds.
//   A transfer at S still completes.
//  Priority in the same cycle: stop > jump_en. start is ignored unless IDLE.
//  Reset mid-operation: immediate return to the reset values above; any
//   in-flight data is lost.
//  Write traffic to the memory is outside this block. Writes during RUN may
//   return old or new data for the written address.
// TESTING
//  1 Preload mem[i]=i+0x100. start, start_addr=4, ready=1 -> cmd_valid 2 cycles
//    later. Then cmd_pc 4,5,6,7... on consecutive cycles, cmd_out=0x104,0x105...
//  2 Same as 1 with ready toggling 1,0,0,1 -> each of 0x104..0x10B seen exactly
//    once, in order. Outputs stable while stalled. Buffer depth never >2.
//  3 ADDR_WIDTH=4, start_addr=14, ready=1 -> cmd_pc 14,15,0,1. Data mem[14],
//    mem[15], mem[0], mem[1].
//  4 Jump with jump_addr=0x20 while cmd_pc=9 is accepted -> 9 transfers; the
//    next 2 cycles have cmd_valid=0. Then cmd_pc=0x20,0x21. No 10 or 11 output.
//  5 stop and jump_en same cycle -> IDLE, busy=0, cmd_valid=0. A later start
//    at 0 gives first cmd_pc=0.
//  6 Assert reset while cmd_valid=1 with 2 entries buffered -> all outputs 0
//    immediately. start after release gives the normal 2-cycle latency.

Source files
------------

// File: rtl/cmd_fetch.sv
// cmd_fetch: command memory read sequencer with 1-cycle read latency absorption and a 2-entry skid buffer
module cmd_fetch #(
  parameter int CMD_WIDTH  = 128,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  stop,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [CMD_WIDTH-1:0]  mem_cmd,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic [ADDR_WIDTH-1:0] cmd_pc,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, fly_addr_q, fly_addr_d;
  logic                  fly_q, fly_d;
  logic [1:0]            cnt_q, cnt_d, cnt_dq;
  logic [CMD_WIDTH-1:0]  buf_cmd_q [2];
  logic [CMD_WIDTH-1:0]  buf_cmd_d [2];
  logic [ADDR_WIDTH-1:0] buf_pc_q [2];
  logic [ADDR_WIDTH-1:0] buf_pc_d [2];
  logic                  deq, slot, issue;
  assign mem_addr  = ptr_q;
  assign cmd_out   = buf_cmd_q[0];
  assign cmd_pc    = buf_pc_q[0];
  assign cmd_valid = cnt_q != 2'd0;
  assign busy      = state_q == RUN;
  assign deq       = cmd_valid & cmd_ready;
  assign cnt_dq    = cnt_q - {1'b0, deq};
  assign slot      = cnt_dq != 2'd0;
  // occupancy counts the landing read, so the buffer can never overflow
  assign issue     = (cnt_dq + {1'b0, fly_q}) < 2'd2;
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    fly_d      = fly_q;
    fly_addr_d = fly_addr_q;
    cnt_d      = cnt_q;
    buf_cmd_d  = buf_cmd_q;
    buf_pc_d   = buf_pc_q;
    if (deq) begin
      buf_cmd_d[0] = buf_cmd_q[1];
      buf_pc_d[0]  = buf_pc_q[1];
    end
    if (state_q == IDLE) begin
      state_d = start ? RUN : IDLE;
      ptr_d   = start ? start_addr : ptr_q;
    end else if (stop || jump_en) begin
      state_d = stop ? IDLE : RUN;
      ptr_d   = stop ? ptr_q : jump_addr;
      cnt_d   = 2'd0;
      fly_d   = 1'b0;
    end else begin
      if (fly_q) begin
        buf_cmd_d[slot] = mem_cmd;
        buf_pc_d[slot]  = fly_addr_q;
      end
      cnt_d      = cnt_dq + {1'b0, fly_q};
      fly_d      = issue;
      fly_addr_d = ptr_q;
      ptr_d      = ptr_q + ADDR_WIDTH'(issue);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      fly_q      <= 1'b0;
      fly_addr_q <= '0;
      cnt_q      <= 2'd0;
      buf_cmd_q  <= '{default: '0};
      buf_pc_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fly_q      <= fly_d;
      fly_addr_q <= fly_addr_d;
      cnt_q      <= cnt_d;
      buf_cmd_q  <= buf_cmd_d;
      buf_pc_q   <= buf_pc_d;
    end
  end
endmodule

// File: tb/tb_cmd_fetch.sv
// tb_cmd_fetch: directed bench with a transaction-level model of the fetch stream
module tb_cmd_fetch;
  logic         clk = 0, reset = 1, start = 0, stop = 0, jump_en = 0, cmd_ready = 0;
  logic [7:0]   start_addr = 0, jump_addr = 0, mem_addr, cmd_pc, ra;
  logic [127:0] mem_cmd, cmd_out;
  logic         cmd_valid, busy;
  logic [127:0] mem [256];
  logic         start4 = 0, v4, b4;
  logic [3:0]   sa4 = 0, ma4, pc4, ra4;
  logic [15:0]  mc4, out4;
  logic [15:0]  mem4 [16];
  int           tests = 0, fails = 0;
  logic [7:0]   acc [$];
  int           e3 [4] = '{14, 15, 0, 1};
  always #5 clk = ~clk;
  cmd_fetch dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
    .jump_en(jump_en), .jump_addr(jump_addr), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
    .cmd_out(cmd_out), .cmd_pc(cmd_pc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy)
  );
  cmd_fetch #(.CMD_WIDTH(16), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .start_addr(sa4), .stop(1'b0),
    .jump_en(1'b0), .jump_addr(4'd0), .mem_addr(ma4), .mem_cmd(mc4),
    .cmd_out(out4), .cmd_pc(pc4), .cmd_valid(v4), .cmd_ready(1'b1), .busy(b4)
  );
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 128'(i + 'h100);
    for (int i = 0; i < 16; i++) mem4[i] = 16'(i + 'h100);
  end
  always @(posedge clk) begin
    ra  <= mem_addr;
    ra4 <= ma4;
  end
  assign mem_cmd = mem[ra];
  assign mc4     = mem4[ra4];
  // stream model: valid two cycles after a (re)direct, pc advances once per transfer
  logic       m_run = 0, m_x;
  int         m_warm = 0;
  logic [7:0] m_pc = 0;
  wire        m_valid = m_run && m_warm >= 2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_warm = 0; m_pc = 0;
    end else begin
      m_x = m_valid && cmd_ready;
      if (!m_run) begin
        if (start) begin m_run = 1; m_warm = 0; m_pc = start_addr; end
      end else if (stop) m_run = 0;
      else if (jump_en) begin m_warm = 0; m_pc = jump_addr; end
      else begin
        if (m_x) m_pc = m_pc + 8'd1;
        if (m_warm < 2) m_warm++;
      end
    end
  end
  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    chk("m_busy", 128'(busy), 128'(m_run));
    chk("m_valid", 128'(cmd_valid), 128'(m_valid));
    if (m_valid) begin
      chk("m_pc", 128'(cmd_pc), 128'(m_pc));
      chk("m_out", cmd_out, 128'(m_pc) + 128'h100);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    tick(2);
    chk("rst_valid", 128'(cmd_valid), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_addr", 128'(mem_addr), 0);
    chk("rst_out", cmd_out, 0);
    reset = 0;
    tick(1);
    start = 1; start_addr = 8'd4; cmd_ready = 1;
    tick(1); start = 0;
    chk("t1_addr", 128'(mem_addr), 4);
    chk("t1_v0", 128'(cmd_valid), 0);
    tick(1);
    chk("t1_v1", 128'(cmd_valid), 0);
    tick(1);
    chk("t1_valid", 128'(cmd_valid), 1);
    chk("t1_pc4", 128'(cmd_pc), 4);
    chk("t1_out4", cmd_out, 128'h104);
    tick(1);
    chk("t1_pc5", 128'(cmd_pc), 5);
    chk("t1_out5", cmd_out, 128'h105);
    tick(4);
    stop = 1; tick(1); stop = 0;
    chk("t1_stop_busy", 128'(busy), 0);
    chk("t1_stop_addr", 128'(mem_addr), 8'h0B);
    tick(2);
    chk("t1_hold_addr", 128'(mem_addr), 8'h0B);
    start = 1; start_addr = 8'd4;
    tick(1); start = 0;
    for (int i = 0; i < 40; i++) begin
      cmd_ready = (i % 4 == 0 || i % 4 == 3);
      if (cmd_valid && cmd_ready) acc.push_back(cmd_pc);
      tick(1);
    end
    chk("t2_count", 128'(acc.size() >= 8), 1);
    for (int k = 0; k < 8 && k < acc.size(); k++) chk("t2_order", 128'(acc[k]), 128'(4 + k));
    cmd_ready = 1; stop = 1; tick(1); stop = 0;
    start = 1; start_addr = 8'hFE;
    tick(1); start = 0;
    tick(2);
    chk("w8_pc0", 128'(cmd_pc), 8'hFE); tick(1);
    chk("w8_pc1", 128'(cmd_pc), 8'hFF); tick(1);
    chk("w8_pc2", 128'(cmd_pc), 8'h00);
    chk("w8_out2", cmd_out, 128'h100);
    stop = 1; tick(1); stop = 0;
    start4 = 1; sa4 = 4'd14;
    tick(1); start4 = 0;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      chk("t3_valid", 128'(v4), 1);
      chk("t3_pc", 128'(pc4), 128'(e3[k]));
      chk("t3_out", 128'(out4), 128'(16'h100 + 16'(e3[k])));
      tick(1);
    end
    start = 1; start_addr = 8'd0;
    tick(1); start = 0;
    for (int k = 0; k < 20 && !(cmd_valid && cmd_pc == 8'd9); k++) tick(1);
    chk("t4_reach9", 128'(cmd_valid && cmd_pc == 8'd9), 1);
    jump_en = 1; jump_addr = 8'h20;
    tick(1); jump_en = 0;
    chk("t4_gap0", 128'(cmd_valid), 0); tick(1);
    chk("t4_gap1", 128'(cmd_valid), 0); tick(1);
    chk("t4_pc20", 128'(cmd_pc), 8'h20);
    chk("t4_v20", 128'(cmd_valid), 1); tick(1);
    chk("t4_pc21", 128'(cmd_pc), 8'h21);
    stop = 1; jump_en = 1; jump_addr = 8'h50;
    tick(1); stop = 0; jump_en = 0;
    chk("t5_busy", 128'(busy), 0);
    chk("t5_valid", 128'(cmd_valid), 0);
    tick(2);
    start = 1; start_addr = 8'd0;
    tick(1); start = 0;
    tick(2);
    chk("t5_pc0", 128'(cmd_pc), 0);
    chk("t5_v", 128'(cmd_valid), 1);
    stop = 1; tick(1); stop = 0;
    start = 1; start_addr = 8'h10; cmd_ready = 0;
    tick(1); start = 0;
    tick(4);
    chk("t6_pre", 128'(cmd_valid), 1);
    #1 reset = 1;
    #1;
    chk("t6_valid", 128'(cmd_valid), 0);
    chk("t6_busy", 128'(busy), 0);
    chk("t6_pc", 128'(cmd_pc), 0);
    chk("t6_out", cmd_out, 0);
    chk("t6_addr", 128'(mem_addr), 0);
    tick(1); reset = 0;
    tick(1);
    start = 1; start_addr = 8'h30; cmd_ready = 1;
    tick(1); start = 0;
    tick(1);
    chk("t6_lat1", 128'(cmd_valid), 0); tick(1);
    chk("t6_lat2", 128'(cmd_valid), 1);
    chk("t6_pc30", 128'(cmd_pc), 8'h30);
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
